// File: rtl/lr_sc_reservation_unit_pkg.sv
// Shared constants and types for the LR/SC reservation unit.
package lr_sc_reservation_unit_pkg;

  // Architectural SC return values written back to rd.
  localparam logic [31:0] SC_SUCCESS = 32'd0;
  localparam logic [31:0] SC_FAIL    = 32'd1;

  // Word granule: byte-offset bits are ignored in reservation compares.
  localparam int DEFAULT_GRANULE_LSB = 2;
  localparam int DEFAULT_ADDR_W      = 32;
  localparam int DEFAULT_GRANULE_W   = DEFAULT_ADDR_W - DEFAULT_GRANULE_LSB;

  // One hart's reservation, as seen by anything that wants to snapshot it.
  typedef struct packed {
    logic                         valid;
    logic [DEFAULT_GRANULE_W-1:0] granule;
  } rsv_entry_t;

  // Map an SC outcome onto the value returned to the writeback path.
  function automatic logic [31:0] sc_result_code(input logic ok);
    return ok ? SC_SUCCESS : SC_FAIL;
  endfunction

endpackage

// File: rtl/lr_sc_reservation_unit_rsv_entry.sv
// One hart's reservation: valid bit, granule address and the match comparator.
// A clear beats a set in the same cycle so a flush always wins over an LR.
module lr_sc_reservation_unit_rsv_entry #(
  parameter int GRAN_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [GRAN_W-1:0] addr_i,
  output logic              valid_o,
  output logic              match_o
);

  logic              valid_q, valid_d;
  logic [GRAN_W-1:0] addr_q, addr_d;

  // Next-state for the valid bit and captured granule.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
    end
    if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign match_o = (addr_q == addr_i);

endmodule

// File: rtl/lr_sc_reservation_unit.sv
// LR/SC reservation unit for the barrel core: one reservation per hart,
// same-cycle SC write gating and a registered SC result for writeback.
module lr_sc_reservation_unit
  import lr_sc_reservation_unit_pkg::*;
#(
  parameter int NUM_HARTS   = 16,
  parameter int HART_ID_W   = $clog2(NUM_HARTS),
  parameter int ADDR_W      = 32,
  parameter int GRANULE_LSB = DEFAULT_GRANULE_LSB
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [HART_ID_W-1:0] i_hart_id,
  input  logic                 i_res_station_valid,
  input  logic                 i_store_cond,
  input  logic                 i_mem_wr,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic                 i_clear_all,
  output logic                 o_sc_mem_we,
  output logic                 o_sc_result_valid,
  output logic [31:0]          o_sc_result,
  output logic [HART_ID_W-1:0] o_sc_hart_id,
  output logic [NUM_HARTS-1:0] o_rsv_valid_vec
);

  localparam int GRAN_W = ADDR_W - GRANULE_LSB;

  logic [GRAN_W-1:0]    gran;
  logic                 unused_addr_lsbs;
  logic                 is_sc, is_lr, is_st;
  logic                 sc_ok;
  logic [NUM_HARTS-1:0] sel_vec;
  logic [NUM_HARTS-1:0] valid_vec;
  logic [NUM_HARTS-1:0] match_vec;
  logic [NUM_HARTS-1:0] hit_vec;
  logic [NUM_HARTS-1:0] set_vec;
  logic [NUM_HARTS-1:0] clr_vec;

  logic                 res_valid_q, res_valid_d;
  logic [31:0]          res_q, res_d;
  logic [HART_ID_W-1:0] res_hart_q, res_hart_d;

  assign gran             = i_addr[ADDR_W-1:GRANULE_LSB];
  assign unused_addr_lsbs = ^i_addr[GRANULE_LSB-1:0];

  // Single issue slot: SC beats LR beats ordinary store.
  assign is_sc = i_valid & i_store_cond;
  assign is_lr = i_valid & ~i_store_cond & i_res_station_valid;
  assign is_st = i_valid & ~i_store_cond & ~i_res_station_valid & i_mem_wr;

  // All SC/store decisions use the registered (pre-update) reservation state.
  assign hit_vec     = valid_vec & match_vec;
  assign sc_ok       = is_sc & (|(sel_vec & hit_vec));
  assign o_sc_mem_we = sc_ok;

  // The flush is not qualified by i_valid: a trap drops reservations on its own.
  // A successful SC or any store kills other harts' matching reservations;
  // an SC always consumes the issuing hart's own reservation.
  assign set_vec = {NUM_HARTS{is_lr}} & sel_vec;
  assign clr_vec = {NUM_HARTS{i_clear_all}}
                 | ({NUM_HARTS{is_sc}} & sel_vec)
                 | ({NUM_HARTS{sc_ok | is_st}} & hit_vec & ~sel_vec);

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_entry
    assign sel_vec[g] = (i_hart_id == HART_ID_W'(g));

    lr_sc_reservation_unit_rsv_entry #(
      .GRAN_W (GRAN_W)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .set_i   (set_vec[g]),
      .clr_i   (clr_vec[g]),
      .addr_i  (gran),
      .valid_o (valid_vec[g]),
      .match_o (match_vec[g])
    );
  end

  // Result next-state: pulse valid for one cycle per SC, hold data otherwise.
  always_comb begin
    res_valid_d = is_sc;
    res_d       = res_q;
    res_hart_d  = res_hart_q;
    if (is_sc) begin
      res_d      = sc_result_code(sc_ok);
      res_hart_d = i_hart_id;
    end
  end

  // Result register for the writeback path.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_q       <= SC_SUCCESS;
      res_hart_q  <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      res_hart_q  <= res_hart_d;
    end
  end

  assign o_sc_result_valid = res_valid_q;
  assign o_sc_result       = res_q;
  assign o_sc_hart_id      = res_hart_q;
  assign o_rsv_valid_vec   = valid_vec;

endmodule

// File: tb/tb_lr_sc_reservation_unit.sv
module tb_lr_sc_reservation_unit;

  localparam int NH = 16;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [HW-1:0] i_hart_id;
  logic          i_res_station_valid;
  logic          i_store_cond;
  logic          i_mem_wr;
  logic [31:0]   i_addr;
  logic          i_clear_all;
  logic          o_sc_mem_we;
  logic          o_sc_result_valid;
  logic [31:0]   o_sc_result;
  logic [HW-1:0] o_sc_hart_id;
  logic [NH-1:0] o_rsv_valid_vec;

  int total = 0;
  int bad   = 0;

  // reference model of the reservation set
  logic        mv [NH];
  logic [29:0] ma [NH];

  typedef struct {
    int          hart;
    logic [31:0] res;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  lr_sc_reservation_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .i_valid             (i_valid),
    .i_hart_id           (i_hart_id),
    .i_res_station_valid (i_res_station_valid),
    .i_store_cond        (i_store_cond),
    .i_mem_wr            (i_mem_wr),
    .i_addr              (i_addr),
    .i_clear_all         (i_clear_all),
    .o_sc_mem_we         (o_sc_mem_we),
    .o_sc_result_valid   (o_sc_result_valid),
    .o_sc_result         (o_sc_result),
    .o_sc_hart_id        (o_sc_hart_id),
    .o_rsv_valid_vec     (o_rsv_valid_vec)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NH-1:0] model_vec();
    logic [NH-1:0] v;
    for (int g = 0; g < NH; g++) v[g] = mv[g];
    return v;
  endfunction

  task automatic model_clear();
    for (int g = 0; g < NH; g++) begin
      mv[g] = 1'b0;
      ma[g] = '0;
    end
  endtask

  // Called just after a rising edge: drive one cycle, check same-cycle
  // mem_we, advance the model, then check result and vector after the edge.
  task automatic step(input logic v, input int h, input logic lr, input logic sc,
                      input logic st, input logic clr, input logic [31:0] addr,
                      input string tag);
    logic [29:0] gr;
    logic        ok;
    exp_t        e;
    gr = addr[31:2];
    i_valid = v; i_hart_id = HW'(h); i_res_station_valid = lr;
    i_store_cond = sc; i_mem_wr = st; i_addr = addr; i_clear_all = clr;
    #1;
    ok = v && sc && mv[h] && (ma[h] == gr);
    chk({tag, ":mem_we"}, {31'd0, o_sc_mem_we}, {31'd0, ok});
    if (v && sc) begin
      e.hart = h;
      e.res  = ok ? 32'd0 : 32'd1;
      sb.push_back(e);
      if (ok)
        for (int g = 0; g < NH; g++)
          if (g != h && mv[g] && ma[g] == gr) mv[g] = 1'b0;
      mv[h] = 1'b0;
    end else if (v && lr) begin
      mv[h] = 1'b1;
      ma[h] = gr;
    end else if (v && st) begin
      for (int g = 0; g < NH; g++)
        if (g != h && mv[g] && ma[g] == gr) mv[g] = 1'b0;
    end
    if (clr) for (int g = 0; g < NH; g++) mv[g] = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0; i_res_station_valid = 1'b0; i_store_cond = 1'b0;
    i_mem_wr = 1'b0; i_clear_all = 1'b0;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ":res_valid"}, {31'd0, o_sc_result_valid}, 32'd1);
      chk({tag, ":result"}, o_sc_result, e.res);
      chk({tag, ":hart"}, {28'd0, o_sc_hart_id}, e.hart[31:0]);
    end else begin
      chk({tag, ":no_result"}, {31'd0, o_sc_result_valid}, 32'd0);
    end
    chk({tag, ":vec"}, {16'd0, o_rsv_valid_vec}, {16'd0, model_vec()});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":res_valid"}, {31'd0, o_sc_result_valid}, 32'd0);
    chk({tag, ":result"}, o_sc_result, 32'd0);
    chk({tag, ":hart"}, {28'd0, o_sc_hart_id}, 32'd0);
    chk({tag, ":vec"}, {16'd0, o_rsv_valid_vec}, 32'd0);
    chk({tag, ":mem_we"}, {31'd0, o_sc_mem_we}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    i_valid = 1'b0; i_hart_id = '0; i_res_station_valid = 1'b0;
    i_store_cond = 1'b0; i_mem_wr = 1'b0; i_addr = '0; i_clear_all = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // 1: LR then back-to-back SC, same hart
    step(1, 3, 1, 0, 0, 0, 32'h1000, "t1_lr");
    step(1, 3, 0, 1, 0, 0, 32'h1000, "t1_sc");

    // 2: SC with no reservation
    step(1, 5, 0, 1, 0, 0, 32'h2000, "t2_sc");

    // 3: foreign store kills matching granule only
    step(1, 1, 1, 0, 0, 0, 32'h3000, "t3_lr1");
    step(1, 2, 1, 0, 0, 0, 32'h3004, "t3_lr2");
    step(1, 7, 0, 0, 1, 0, 32'h3002, "t3_st7");
    step(1, 1, 0, 1, 0, 0, 32'h3000, "t3_sc1");
    step(1, 2, 0, 1, 0, 0, 32'h3004, "t3_sc2");

    // 4: successful SC kills other harts on the same granule
    step(1, 0, 1, 0, 0, 0, 32'h4000, "t4_lr0");
    step(1, 9, 1, 0, 0, 0, 32'h4000, "t4_lr9");
    step(1, 0, 0, 1, 0, 0, 32'h4000, "t4_sc0");
    step(1, 9, 0, 1, 0, 0, 32'h4000, "t4_sc9");

    // 5: clear_all beats LR; same-cycle SC uses pre-clear state
    step(1, 4, 1, 0, 0, 0, 32'h5000, "t5_lr4");
    step(1, 6, 1, 0, 0, 1, 32'h6000, "t5_clr_lr6");
    step(1, 6, 0, 1, 0, 0, 32'h6000, "t5_sc6");
    step(1, 4, 1, 0, 0, 0, 32'h5000, "t5_lr4b");
    step(1, 4, 0, 1, 0, 1, 32'h5000, "t5_clr_sc4");
    step(1, 4, 0, 1, 0, 0, 32'h5000, "t5_sc4_after");

    // misaligned addresses share the word granule
    step(1, 8, 1, 0, 0, 0, 32'h7001, "mis_lr");
    step(1, 8, 0, 1, 0, 0, 32'h7003, "mis_sc");

    // own store keeps own reservation; different granule does not match
    step(1, 10, 1, 0, 0, 0, 32'h8000, "own_lr");
    step(1, 10, 0, 0, 1, 0, 32'h8000, "own_st");
    step(1, 10, 0, 1, 0, 0, 32'h8000, "own_sc");
    step(1, 11, 1, 0, 0, 0, 32'h8100, "gr_lr");
    step(1, 11, 0, 1, 0, 0, 32'h8104, "gr_sc");

    // priority SC > LR > store, and i_valid low has no effect
    step(1, 12, 1, 0, 0, 0, 32'hA000, "pri_lr");
    step(0, 12, 0, 1, 0, 0, 32'hA000, "inv_sc");
    step(0, 13, 1, 0, 0, 0, 32'hB000, "inv_lr");
    step(1, 12, 1, 1, 1, 0, 32'hA000, "pri_all");
    step(1, 12, 0, 1, 0, 0, 32'hA000, "pri_sc_again");
    step(1, 14, 1, 0, 0, 0, 32'hC000, "pri_lr14");
    step(1, 15, 1, 0, 1, 0, 32'hC000, "pri_lr_st");
    step(1, 14, 0, 1, 0, 0, 32'hC000, "pri_sc14");

    // 6: reset in the SC result cycle
    step(1, 2, 1, 0, 0, 0, 32'h9000, "t6_lr");
    step(1, 2, 0, 1, 0, 0, 32'h9000, "t6_sc");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    chk_zero("t6_reset");
    step(1, 2, 0, 1, 0, 0, 32'h9000, "t6_sc_after");

    // reset in the same cycle as an SC discards its result
    step(1, 2, 1, 0, 0, 0, 32'h9000, "t6b_lr");
    i_valid = 1'b1; i_hart_id = 4'd2; i_store_cond = 1'b1; i_addr = 32'h9000;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_valid = 1'b0; i_store_cond = 1'b0;
    model_clear();
    chk_zero("t6b_reset_sc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lr_sc_reservation_unit.md
Name: lr_sc_reservation_unit

Overview:
- Responder for the LR/SC atomic signals produced by the control unit (reservation-set for LR, store-conditional flag for SC).
- Holds one address reservation per hart of the barrel core.
- Decides SC success in the same cycle, so the SC's data-memory write enable is gated in that cycle.
- Returns the architectural SC result (0 = success, 1 = fail) one cycle later for the writeback path (WBSel = 11).

Parameters:
- NUM_HARTS, 16, number of hardware threads; one reservation entry each.
- HART_ID_W, $clog2(NUM_HARTS), width of the hart index.
- ADDR_W, 32, byte-address width.
- GRANULE_LSB, 2, reservation granule. Address bits below this are ignored in compares (word granule).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- i_valid  in  1  qualifies all request inputs this cycle.
- i_hart_id  in  HART_ID_W  issuing hart.
- i_res_station_valid  in  1  LR: set the reservation.
- i_store_cond  in  1  SC request.
- i_mem_wr  in  1  ordinary store.
- i_addr  in  ADDR_W  effective address (rs1 for LR/SC, rs1+imm for stores).
- i_clear_all  in  1  drop every reservation (trap/flush).
- o_sc_mem_we  out  1  combinational; SC permitted to write memory this cycle.
- o_sc_result_valid  out  1  registered; SC result available.
- o_sc_result  out  32  registered; 32'd0 on success, 32'd1 on fail.
- o_sc_hart_id  out  HART_ID_W  registered; hart owning o_sc_result.
- o_rsv_valid_vec  out  NUM_HARTS  registered; per-hart reservation-valid bits (debug).

Behaviour:

Reset:
- All reservation valid bits and addresses are cleared to 0.
- o_sc_result_valid = 0, o_sc_result = 0, o_sc_hart_id = 0, o_rsv_valid_vec = 0.
- o_sc_mem_we = 0, since the reservation state is empty.

State and request qualification:
- Per hart h: rsv_valid[h] and rsv_addr[h] = i_addr[ADDR_W-1:GRANULE_LSB].
- Requests take effect only when i_valid = 1. At most one request per cycle (single issue slot).
- If more than one of LR/SC/store is asserted, priority is SC > LR > store; the lower-priority requests are ignored.
- Granule match: match = (rsv_addr[x] == i_addr[ADDR_W-1:GRANULE_LSB]).

LR from hart h:
- Next cycle: rsv_valid[h] = 1 and rsv_addr[h] = the granule.
- Any older reservation of h is overwritten.
- Other harts are unaffected.

SC from hart h:
- ok = rsv_valid[h] & match(h), evaluated on pre-update state.
- o_sc_mem_we = ok, combinational, in the same cycle.
- Next cycle: rsv_valid[h] = 0 regardless of ok.
- If ok, every other hart g with rsv_valid[g] & match(g) is also cleared.
- Next cycle: o_sc_result_valid = 1, o_sc_result = ok ? 0 : 1, o_sc_hart_id = h.
- o_sc_result_valid is a single-cycle pulse with no backpressure.

Ordinary store from hart h:
- Clears rsv_valid[g] for every g != h with a granule match.
- h's own reservation is kept.

i_clear_all:
- All rsv_valid bits are 0 next cycle.
- Overrides an LR set in the same cycle.
- A same-cycle SC is still evaluated on pre-clear state (o_sc_mem_we and the result use the old state).

Other cases:
- Back-to-back LR then SC from the same hart in consecutive cycles: the SC sees the LR's update.
- i_valid = 0: state holds and o_sc_result_valid = 0 next cycle.
- Reset mid-operation: a pending result is discarded; o_sc_result_valid = 0 in the cycle after reset.
- Misaligned LR/SC addresses are not trapped here; bits below GRANULE_LSB are ignored.

Decomposition:
- Shared package:
  - SC_SUCCESS = 32'd0 and SC_FAIL = 32'd1.
  - DEFAULT_GRANULE_LSB.
  - A typedef for the reservation entry {valid, granule address}.
- Sub-module rsv_entry: one hart's valid bit and address register plus the match comparator, with set/clear inputs. Instantiated NUM_HARTS times via generate. The top level does the hart decode, clear-vector build and result register.

Test Plan:
1. LR hart 3 @0x1000; next cycle SC hart 3 @0x1000 -> o_sc_mem_we = 1 that cycle; next cycle o_sc_result_valid = 1, o_sc_result = 0, o_sc_hart_id = 3; o_rsv_valid_vec[3] = 0.
2. SC hart 5 @0x2000 with no prior LR -> o_sc_mem_we = 0; o_sc_result = 1.
3. LR hart 1 @0x3000, LR hart 2 @0x3004, store hart 7 @0x3002 -> rsv_valid[1] = 0, rsv_valid[2] = 1; SC hart 1 @0x3000 gives result 1; SC hart 2 @0x3004 gives result 0.
4. LR hart 0 @0x4000, LR hart 9 @0x4000, SC hart 0 @0x4000 succeeds -> rsv_valid[9] = 0; SC hart 9 then returns 1.
5. LR hart 4 @0x5000, then i_clear_all together with LR hart 6 @0x6000 -> o_rsv_valid_vec = 0; SC hart 4 @0x5000 in the clear cycle still sees the old state and succeeds.
6. LR hart 2, SC hart 2, reset asserted in the SC result cycle -> outputs 0 and vector 0 the cycle after reset; a later SC hart 2 returns 1.
